// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a sync FIFO with one-cycle read latency into a 2-entry registered valid/ready stream
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [1:0]            buf_cnt
);
  logic [1:0]            occ_q, occ_d;
  logic                  head_q, head_d;
  logic                  inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0] entry_q [2];
  logic                  tail, pop, cap;
  logic [2:0]            pending;
  assign m_valid = rst_n & (occ_q != 2'd0);
  assign m_data  = rst_n ? entry_q[head_q] : '0;
  assign buf_cnt = rst_n ? occ_q : 2'd0;
  // Issue only when the word would still fit after this cycle's pop.
  always_comb begin
    pop        = m_valid & m_ready;
    cap        = inflight_q & ~flush;
    tail       = head_q ^ occ_q[0];
    pending    = {1'b0, occ_q} + {2'b0, inflight_q} - {2'b0, pop};
    fifo_rd_en = rst_n & ~flush & ~fifo_empty & (pending < 3'd2);
    occ_d      = flush ? 2'd0 : occ_q + {1'b0, cap} - {1'b0, pop};
    head_d     = flush ? 1'b0 : head_q ^ pop;
    inflight_d = fifo_rd_en;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_q      <= 2'd0;
      head_q     <= 1'b0;
      inflight_q <= 1'b0;
      entry_q[0] <= '0;
      entry_q[1] <= '0;
    end else begin
      occ_q      <= occ_d;
      head_q     <= head_d;
      inflight_q <= inflight_d;
      if (cap) entry_q[tail] <= fifo_data;
    end
  end
  assert property (@(posedge clk) disable iff (!rst_n) ({1'b0, occ_q} + {2'b0, inflight_q} <= 3'd2));
endmodule
